// File: rtl/dyt_fetch_unit_pkg.sv
// Shared types for the instruction-fetch stage: word type, fetch FSM states,
// the bubble encoding and the instruction/PC packet carried through the skid.
package dyt_fetch_unit_pkg;

   typedef logic [31:0] word_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BUSY  = 2'd1,
      DRAIN = 2'd2
   } fetch_state_t;

   localparam word_t NOP_INSTR = 32'h0000_0013;
   localparam word_t PC_STEP   = 32'd4;

   typedef struct packed {
      word_t instr;
      word_t pc;
   } fetch_pkt_t;

   function automatic word_t align_word(input word_t a);
      return {a[31:2], 2'b00};
   endfunction

endpackage

// File: rtl/dyt_fetch_skid.sv
// One-entry skid buffer holding a fetched instruction/PC pair while ID stalls.
// Flush wins over push; a push together with a pop reloads the entry.
module dyt_fetch_skid
   import dyt_fetch_unit_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       push_i,
   input  logic       pop_i,
   input  logic       flush_i,
   input  fetch_pkt_t pkt_i,
   output fetch_pkt_t pkt_o,
   output logic       full_o
);

   fetch_pkt_t pkt_q;
   logic       full_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         full_q <= 1'b0;
         pkt_q  <= '0;
      end else if (flush_i) begin
         full_q <= 1'b0;
      end else if (push_i) begin
         full_q <= 1'b1;
         pkt_q  <= pkt_i;
      end else if (pop_i) begin
         full_q <= 1'b0;
      end
   end

   assign pkt_o  = pkt_q;
   assign full_o = full_q;

endmodule

// File: rtl/dyt_fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues word reads over a ren/ready
// handshake and drives the registered IF/ID latch inputs with a one-entry skid.
//
//   state | meaning
//   IDLE  | no request outstanding; issues from pc once the skid is empty
//   BUSY  | request at imem_addr_o outstanding; deliveries go to output or skid
//   DRAIN | request outstanding but its response is stale and will be dropped
module dyt_fetch_unit
   import dyt_fetch_unit_pkg::*;
#(
   parameter word_t RESET_PC  = 32'h0000_0000,
   parameter word_t NOP_INSTR = dyt_fetch_unit_pkg::NOP_INSTR
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_ren_o,
   output logic [31:0] imem_addr_o,
   input  logic [31:0] imem_rdata_i,
   input  logic        imem_ready_i,
   input  logic        stall_i,
   input  logic        redirect_i,
   input  logic [31:0] redirect_pc_i,
   output logic [31:0] ifid_instruction_o,
   output logic [31:0] ifid_pc_o,
   output logic        ifid_valid_o
);

   fetch_state_t state_q;
   word_t        pc_q;
   word_t        addr_q;
   word_t        instr_q;
   word_t        opc_q;
   logic         ren_q;
   logic         valid_q;

   word_t        redir_pc;
   word_t        next_addr;
   fetch_pkt_t   dlv_pkt;
   fetch_pkt_t   skid_pkt;
   logic         dlv;
   logic         advance;
   logic         skid_full;
   logic         skid_push;
   logic         skid_pop;
   logic         skid_full_d;

   assign redir_pc  = align_word(redirect_pc_i);
   assign next_addr = addr_q + PC_STEP;
   assign dlv_pkt   = '{instr: imem_rdata_i, pc: addr_q};

   // A response only counts as a delivery when it is not being redirected away.
   assign dlv       = (state_q == BUSY) && imem_ready_i && !redirect_i;
   assign advance   = valid_q && !stall_i;
   assign skid_push = dlv && valid_q && stall_i;
   assign skid_pop  = advance && skid_full && !redirect_i;
   assign skid_full_d = !redirect_i && (skid_push || (skid_full && !skid_pop));

   dyt_fetch_skid u_skid (
      .clk     (clk),
      .rst     (rst),
      .push_i  (skid_push),
      .pop_i   (skid_pop),
      .flush_i (redirect_i),
      .pkt_i   (dlv_pkt),
      .pkt_o   (skid_pkt),
      .full_o  (skid_full)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         pc_q    <= RESET_PC;
         addr_q  <= RESET_PC;
         ren_q   <= 1'b0;
         instr_q <= NOP_INSTR;
         opc_q   <= RESET_PC;
         valid_q <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (redirect_i) begin
                  pc_q <= redir_pc;
               end else if (!skid_full) begin
                  addr_q  <= pc_q;
                  ren_q   <= 1'b1;
                  state_q <= BUSY;
               end
            end
            BUSY: begin
               if (redirect_i) begin
                  pc_q <= redir_pc;
                  if (imem_ready_i) begin
                     ren_q   <= 1'b0;
                     state_q <= IDLE;
                  end else begin
                     state_q <= DRAIN;
                  end
               end else if (imem_ready_i) begin
                  pc_q <= next_addr;
                  if (skid_full_d) begin
                     ren_q   <= 1'b0;
                     state_q <= IDLE;
                  end else begin
                     addr_q <= next_addr;
                  end
               end
            end
            DRAIN: begin
               if (redirect_i) pc_q <= redir_pc;
               if (imem_ready_i) begin
                  ren_q   <= 1'b0;
                  state_q <= IDLE;
               end
            end
            default: begin
               ren_q   <= 1'b0;
               state_q <= IDLE;
            end
         endcase

         // Redirect kills the output slot even while ID is stalling.
         if (redirect_i) begin
            valid_q <= 1'b0;
            instr_q <= NOP_INSTR;
         end else if (advance) begin
            if (skid_full) begin
               valid_q <= 1'b1;
               instr_q <= skid_pkt.instr;
               opc_q   <= skid_pkt.pc;
            end else if (dlv) begin
               valid_q <= 1'b1;
               instr_q <= dlv_pkt.instr;
               opc_q   <= dlv_pkt.pc;
            end else begin
               valid_q <= 1'b0;
               instr_q <= NOP_INSTR;
            end
         end else if (!valid_q && dlv) begin
            valid_q <= 1'b1;
            instr_q <= dlv_pkt.instr;
            opc_q   <= dlv_pkt.pc;
         end
      end
   end

   assign imem_ren_o         = ren_q;
   assign imem_addr_o        = addr_q;
   assign ifid_instruction_o = instr_q;
   assign ifid_pc_o          = opc_q;
   assign ifid_valid_o       = valid_q;

endmodule

// File: tb/tb_dyt_fetch_unit.sv
// Self-checking bench for dyt_fetch_unit: directed scenarios plus a randomized
// run scored against a program-order model of the fetched instruction stream.
module tb_dyt_fetch_unit;

   localparam logic [31:0] RST_PC = 32'h0000_0000;
   localparam logic [31:0] NOP    = 32'h0000_0013;

   logic        clk;
   logic        rst;
   logic        imem_ren_o;
   logic [31:0] imem_addr_o;
   logic [31:0] imem_rdata_i;
   logic        imem_ready_i;
   logic        stall_i;
   logic        redirect_i;
   logic [31:0] redirect_pc_i;
   logic [31:0] ifid_instruction_o;
   logic [31:0] ifid_pc_o;
   logic        ifid_valid_o;

   int n_cmp = 0;
   int n_err = 0;
   int mem_mode = 0;   // 0: ready tied high, 1: fixed latency, 2: random ready
   int mem_lat = 3;
   int wait_cnt = 0;

   dyt_fetch_unit dut (
      .clk                (clk),
      .rst                (rst),
      .imem_ren_o         (imem_ren_o),
      .imem_addr_o        (imem_addr_o),
      .imem_rdata_i       (imem_rdata_i),
      .imem_ready_i       (imem_ready_i),
      .stall_i            (stall_i),
      .redirect_i         (redirect_i),
      .redirect_pc_i      (redirect_pc_i),
      .ifid_instruction_o (ifid_instruction_o),
      .ifid_pc_o          (ifid_pc_o),
      .ifid_valid_o       (ifid_valid_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog: got no finish expected finish before time limit");
      $fatal(1, "watchdog expired");
   end

   function automatic logic [31:0] instr_at(input logic [31:0] a);
      return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
   endfunction

   task automatic drive_mem();
      case (mem_mode)
         0: imem_ready_i = 1'b1;
         1: begin
            if (imem_ren_o) begin
               imem_ready_i = (wait_cnt + 1 >= mem_lat);
               wait_cnt = imem_ready_i ? 0 : wait_cnt + 1;
            end else begin
               imem_ready_i = 1'b0;
               wait_cnt = 0;
            end
         end
         default: imem_ready_i = ($urandom_range(0, 1) == 1);
      endcase
      imem_rdata_i = imem_ready_i ? instr_at(imem_addr_o) : $urandom();
   endtask

   task automatic tick();
      drive_mem();
      @(posedge clk);
      #1;
   endtask

   task automatic reset_dut();
      rst = 1'b1;
      stall_i = 1'b0;
      redirect_i = 1'b0;
      redirect_pc_i = '0;
      imem_ready_i = 1'b0;
      imem_rdata_i = '0;
      wait_cnt = 0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic wait_ren(input int bound, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < bound; i++) begin
         if (imem_ren_o) begin
            ok = 1'b1;
            break;
         end
         tick();
      end
   endtask

   task automatic wait_valid(input int bound, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < bound; i++) begin
         if (ifid_valid_o) begin
            ok = 1'b1;
            break;
         end
         tick();
      end
   endtask

   task automatic wait_out_pc(input logic [31:0] pc, input int bound, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < bound; i++) begin
         if (ifid_valid_o && ifid_pc_o == pc) begin
            ok = 1'b1;
            break;
         end
         tick();
      end
   endtask

   task automatic test_reset();
      reset_dut();
      n_cmp++;
      if ({imem_ren_o, imem_addr_o, ifid_instruction_o, ifid_pc_o, ifid_valid_o} !==
          {1'b0, RST_PC, NOP, RST_PC, 1'b0}) begin
         n_err++;
         $display("FAIL reset_values: got ren=%b addr=%h instr=%h pc=%h valid=%b expected 0/%h/%h/%h/0",
                  imem_ren_o, imem_addr_o, ifid_instruction_o, ifid_pc_o, ifid_valid_o, RST_PC, NOP, RST_PC);
      end
   endtask

   task automatic test_back_to_back();
      bit ok;
      reset_dut();
      mem_mode = 0;
      wait_ren(10, ok);
      n_cmp++;
      if (!ok) begin n_err++; $display("FAIL b2b_first_req: got no request expected request"); end
      for (int k = 0; k < 3; k++) begin
         n_cmp++;
         if (imem_addr_o !== 32'(4 * k)) begin
            n_err++; $display("FAIL b2b_addr: got %h expected %h", imem_addr_o, 32'(4 * k));
         end
         if (k > 0) begin
            n_cmp++;
            if (!ifid_valid_o || ifid_pc_o !== 32'(4 * (k - 1))) begin
               n_err++; $display("FAIL b2b_out: got valid=%b pc=%h expected 1/%h", ifid_valid_o, ifid_pc_o, 32'(4 * (k - 1)));
            end
         end
         tick();
      end
      for (int j = 0; j < 4; j++) begin
         n_cmp++;
         if (!ifid_valid_o || ifid_pc_o !== 32'(8 + 4 * j) || ifid_instruction_o !== instr_at(32'(8 + 4 * j))) begin
            n_err++; $display("FAIL b2b_stream: got valid=%b pc=%h instr=%h expected 1/%h/%h",
                              ifid_valid_o, ifid_pc_o, ifid_instruction_o, 32'(8 + 4 * j), instr_at(32'(8 + 4 * j)));
         end
         tick();
      end
   endtask

   task automatic test_latency();
      bit ok;
      bit exp_v;
      reset_dut();
      mem_mode = 1;
      mem_lat = 3;
      wait_ren(10, ok);
      n_cmp++;
      if (!ok) begin n_err++; $display("FAIL lat_first_req: got no request expected request"); end
      for (int k = 0; k < 4; k++) begin
         for (int j = 0; j < 3; j++) begin
            n_cmp++;
            if (!imem_ren_o || imem_addr_o !== 32'(4 * k)) begin
               n_err++; $display("FAIL lat_addr: got ren=%b addr=%h expected 1/%h", imem_ren_o, imem_addr_o, 32'(4 * k));
            end
            exp_v = (j == 0 && k > 0);
            n_cmp++;
            if (ifid_valid_o !== exp_v) begin
               n_err++; $display("FAIL lat_valid: got %b expected %b", ifid_valid_o, exp_v);
            end
            n_cmp++;
            if (exp_v) begin
               if (ifid_pc_o !== 32'(4 * (k - 1)) || ifid_instruction_o !== instr_at(32'(4 * (k - 1)))) begin
                  n_err++; $display("FAIL lat_data: got pc=%h instr=%h expected %h/%h",
                                    ifid_pc_o, ifid_instruction_o, 32'(4 * (k - 1)), instr_at(32'(4 * (k - 1))));
               end
            end else if (ifid_instruction_o !== NOP) begin
               n_err++; $display("FAIL lat_bubble: got %h expected %h", ifid_instruction_o, NOP);
            end
            tick();
         end
      end
   endtask

   task automatic test_stall();
      bit ok;
      reset_dut();
      mem_mode = 0;
      wait_out_pc(32'h8, 20, ok);
      n_cmp++;
      if (!ok) begin n_err++; $display("FAIL stall_reach8: got no pc 8 expected pc 8"); end
      stall_i = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         n_cmp++;
         if ({ifid_valid_o, ifid_pc_o, ifid_instruction_o, imem_ren_o} !== {1'b1, 32'h8, instr_at(32'h8), 1'b0}) begin
            n_err++; $display("FAIL stall_hold: got valid=%b pc=%h instr=%h ren=%b expected 1/8/%h/0",
                              ifid_valid_o, ifid_pc_o, ifid_instruction_o, imem_ren_o, instr_at(32'h8));
         end
      end
      stall_i = 1'b0;
      tick();
      n_cmp++;
      if (!ifid_valid_o || ifid_pc_o !== 32'hC || ifid_instruction_o !== instr_at(32'hC)) begin
         n_err++; $display("FAIL stall_skid_out: got valid=%b pc=%h instr=%h expected 1/c/%h",
                           ifid_valid_o, ifid_pc_o, ifid_instruction_o, instr_at(32'hC));
      end
      tick();
      wait_ren(10, ok);
      n_cmp++;
      if (!ok || imem_addr_o !== 32'h10) begin
         n_err++; $display("FAIL stall_resume_addr: got ren=%b addr=%h expected 1/10", imem_ren_o, imem_addr_o);
      end
      wait_valid(10, ok);
      n_cmp++;
      if (!ok || ifid_pc_o !== 32'h10) begin
         n_err++; $display("FAIL stall_resume_out: got valid=%b pc=%h expected 1/10", ifid_valid_o, ifid_pc_o);
      end
   endtask

   task automatic test_redirect_drain();
      bit ok;
      bit seen = 1'b0;
      reset_dut();
      mem_mode = 1;
      mem_lat = 3;
      wait_ren(10, ok);
      redirect_i = 1'b1;
      redirect_pc_i = 32'h100;
      tick();
      redirect_i = 1'b0;
      n_cmp++;
      if (!ok || !imem_ren_o || imem_addr_o !== 32'h0 || ifid_valid_o !== 1'b0) begin
         n_err++; $display("FAIL drain_hold: got ren=%b addr=%h valid=%b expected 1/0/0", imem_ren_o, imem_addr_o, ifid_valid_o);
      end
      ok = 1'b0;
      for (int i = 0; i < 30; i++) begin
         if (imem_ren_o && imem_addr_o !== 32'h0 && !seen) begin
            seen = 1'b1;
            n_cmp++;
            if (imem_addr_o !== 32'h100) begin
               n_err++; $display("FAIL drain_next_addr: got %h expected 100", imem_addr_o);
            end
         end
         if (ifid_valid_o) begin ok = 1'b1; break; end
         tick();
      end
      n_cmp++;
      if (!ok || !seen || ifid_pc_o !== 32'h100 || ifid_instruction_o !== instr_at(32'h100)) begin
         n_err++; $display("FAIL drain_first_out: got valid=%b pc=%h instr=%h expected 1/100/%h",
                           ifid_valid_o, ifid_pc_o, ifid_instruction_o, instr_at(32'h100));
      end
   endtask

   task automatic test_redirect_stall();
      bit ok;
      reset_dut();
      mem_mode = 0;
      wait_out_pc(32'h8, 20, ok);
      stall_i = 1'b1;
      tick();
      tick();
      redirect_i = 1'b1;
      redirect_pc_i = 32'h200;
      tick();
      redirect_i = 1'b0;
      n_cmp++;
      if (!ok || ifid_valid_o !== 1'b0 || ifid_instruction_o !== NOP) begin
         n_err++; $display("FAIL rs_flush: got valid=%b instr=%h expected 0/%h", ifid_valid_o, ifid_instruction_o, NOP);
      end
      wait_valid(20, ok);
      n_cmp++;
      if (!ok || ifid_pc_o !== 32'h200 || ifid_instruction_o !== instr_at(32'h200)) begin
         n_err++; $display("FAIL rs_target: got valid=%b pc=%h instr=%h expected 1/200/%h",
                           ifid_valid_o, ifid_pc_o, ifid_instruction_o, instr_at(32'h200));
      end
      stall_i = 1'b0;
   endtask

   task automatic test_wrap();
      bit ok;
      reset_dut();
      mem_mode = 0;
      repeat (3) tick();
      redirect_i = 1'b1;
      redirect_pc_i = 32'hFFFF_FFFE;
      tick();
      redirect_i = 1'b0;
      wait_valid(20, ok);
      n_cmp++;
      if (!ok || ifid_pc_o !== 32'hFFFF_FFFC || ifid_instruction_o !== instr_at(32'hFFFF_FFFC)) begin
         n_err++; $display("FAIL wrap_target: got valid=%b pc=%h expected 1/fffffffc", ifid_valid_o, ifid_pc_o);
      end
      tick();
      n_cmp++;
      if (!ifid_valid_o || ifid_pc_o !== 32'h0 || ifid_instruction_o !== instr_at(32'h0)) begin
         n_err++; $display("FAIL wrap_next: got valid=%b pc=%h expected 1/00000000", ifid_valid_o, ifid_pc_o);
      end
   endtask

   task automatic test_async_reset();
      reset_dut();
      mem_mode = 0;
      repeat (5) tick();
      #2;
      rst = 1'b1;
      #1;
      n_cmp++;
      if ({imem_ren_o, imem_addr_o, ifid_instruction_o, ifid_pc_o, ifid_valid_o} !==
          {1'b0, RST_PC, NOP, RST_PC, 1'b0}) begin
         n_err++; $display("FAIL async_reset: got ren=%b addr=%h instr=%h pc=%h valid=%b expected reset values",
                           imem_ren_o, imem_addr_o, ifid_instruction_o, ifid_pc_o, ifid_valid_o);
      end
      reset_dut();
   endtask

   task automatic test_random();
      logic [31:0] exp_pc;
      logic [31:0] pv_pc, pv_instr, pv_addr;
      logic        pv_valid, pv_stall, pv_redir, pv_ren, pv_ready;
      int          consumed = 0;
      reset_dut();
      mem_mode = 2;
      exp_pc = RST_PC;
      {pv_valid, pv_stall, pv_redir, pv_ren, pv_ready} = '0;
      pv_pc = '0; pv_instr = '0; pv_addr = '0;
      for (int c = 0; c < 3000; c++) begin
         if (pv_redir) begin
            n_cmp++;
            if (ifid_valid_o !== 1'b0 || ifid_instruction_o !== NOP) begin
               n_err++; $display("FAIL rnd_redirect_kill: got valid=%b instr=%h expected 0/%h", ifid_valid_o, ifid_instruction_o, NOP);
            end
         end else if (pv_valid && pv_stall) begin
            n_cmp++;
            if ({ifid_valid_o, ifid_pc_o, ifid_instruction_o} !== {1'b1, pv_pc, pv_instr}) begin
               n_err++; $display("FAIL rnd_stall_hold: got %b/%h/%h expected 1/%h/%h",
                                 ifid_valid_o, ifid_pc_o, ifid_instruction_o, pv_pc, pv_instr);
            end
         end
         if (!ifid_valid_o) begin
            n_cmp++;
            if (ifid_instruction_o !== NOP) begin
               n_err++; $display("FAIL rnd_bubble: got %h expected %h", ifid_instruction_o, NOP);
            end
         end
         if (pv_ren && !pv_ready) begin
            n_cmp++;
            if (!imem_ren_o || imem_addr_o !== pv_addr) begin
               n_err++; $display("FAIL rnd_req_stable: got ren=%b addr=%h expected 1/%h", imem_ren_o, imem_addr_o, pv_addr);
            end
         end
         stall_i = ($urandom_range(0, 3) == 0);
         redirect_i = ($urandom_range(0, 31) == 0);
         redirect_pc_i = $urandom();
         if (ifid_valid_o && !stall_i && !redirect_i) begin
            n_cmp++;
            if (ifid_pc_o !== exp_pc || ifid_instruction_o !== instr_at(exp_pc)) begin
               n_err++; $display("FAIL rnd_stream: got pc=%h instr=%h expected %h/%h",
                                 ifid_pc_o, ifid_instruction_o, exp_pc, instr_at(exp_pc));
               exp_pc = ifid_pc_o;
            end
            exp_pc = exp_pc + 32'd4;
            consumed++;
         end
         if (redirect_i) exp_pc = redirect_pc_i & ~32'h3;
         pv_valid = ifid_valid_o;
         pv_pc = ifid_pc_o;
         pv_instr = ifid_instruction_o;
         pv_stall = stall_i;
         pv_redir = redirect_i;
         pv_ren = imem_ren_o;
         pv_addr = imem_addr_o;
         tick();
         pv_ready = imem_ready_i;
      end
      stall_i = 1'b0;
      redirect_i = 1'b0;
      n_cmp++;
      if (consumed < 300) begin
         n_err++; $display("FAIL rnd_progress: got %0d consumed expected at least 300", consumed);
      end
   endtask

   initial begin
      rst = 1'b1;
      stall_i = 1'b0;
      redirect_i = 1'b0;
      redirect_pc_i = '0;
      imem_ready_i = 1'b0;
      imem_rdata_i = '0;
      test_reset();
      test_back_to_back();
      test_latency();
      test_stall();
      test_redirect_drain();
      test_redirect_stall();
      test_wrap();
      test_async_reset();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
